kanagawa_hal_mock_sp_ram_ext: RTL and testbench
===============================================

Name: kanagawa_hal_mock_sp_ram_ext

Overview:
- Simulation-only mock of a simple dual-port RAM (one read port, one write port) on a single clock, for HAL builds.
- Successor to the dual-clock mock. Adds parametrised read latency, byte-enable writes, a selectable read-during-write mode, read-valid tracking and a post-reset memory initialisation sweep.
- Sits under Kanagawa-generated memories wherever a single-clock RAM primitive is instantiated in simulation.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of BYTE_WIDTH (elaboration error otherwise).
- ADDR_WIDTH, 9, address width; DEPTH = 2**ADDR_WIDTH.
- BYTE_WIDTH, 8, bits per byte-enable lane; NUM_BYTES = DATA_WIDTH/BYTE_WIDTH.
- READ_LATENCY, 2, cycles from rden_in to rdvalid_out; legal range 1..4 (elaboration error outside it).
- RDW_MODE, 0, same-address read-during-write result: 0 = old data, 1 = new (merged) data.
- INIT_VALUE, 0, DATA_WIDTH-bit value written to every word by the init sweep.
- DEVICE_FAMILY, "mock", unused; kept for HAL signature compatibility.

Ports:
- clk  input  1  single clock for all logic.
- rst_n  input  1  reset; asynchronous, active-low.
- ready_out  output  1  1 once the init sweep has completed.
- rden_in  input  1  read request.
- readaddr_in  input  ADDR_WIDTH  read address.
- rdvalid_out  output  1  data_out carries the result of a read issued READ_LATENCY cycles earlier.
- data_out  output  DATA_WIDTH  read data.
- wren_in  input  1  write request.
- writeaddr_in  input  ADDR_WIDTH  write address.
- byteen_in  input  NUM_BYTES  per-lane write enable; bit i covers bits [i*BYTE_WIDTH +: BYTE_WIDTH].
- data_in  input  DATA_WIDTH  write data.

Behaviour:
- Reset:
  - Assertion of rst_n is asynchronous: state=INIT, init counter=0, ready_out=0, rdvalid_out=0, all read pipeline valid bits=0, data_out=0.
  - Memory array is not reset directly.
- State machine INIT:
  - Each cycle after rst_n deasserts, writes INIT_VALUE to mem[counter] and increments the counter.
  - When counter==DEPTH-1 is written, next state is RUN and ready_out rises.
  - ready_out is first 1 in the DEPTH-th cycle after reset release.
- State machine RUN: terminal until the next reset.
- During INIT: wren_in and rden_in are ignored. No write, no pipeline entry, rdvalid_out stays 0.
- Write (RUN, wren_in=1): at the clock edge, lanes with byteen_in[i]=1 are updated and the other lanes are kept. byteen_in=0 means no change.
- Read (RUN, rden_in=1 at edge t):
  - Array sampled at edge t.
  - Data advances through a READ_LATENCY-deep register pipe with a parallel valid pipe.
  - data_out and rdvalid_out are updated at edge t+READ_LATENCY-1, so they are visible during cycle t+READ_LATENCY-1 → t+READ_LATENCY.
  - Back-to-back reads are fully pipelined, one per cycle.
- When the emerging pipe slot is invalid, rdvalid_out=0 and data_out holds its previous value.
- Same-address read and write in the same cycle:
  - RDW_MODE=0: read returns the pre-write word.
  - RDW_MODE=1: read returns enabled lanes from data_in and the remaining lanes from the old word.
- Different-address simultaneous read/write: independent.
- A write at cycle t is visible to any read issued at t+1 or later.
- Address wrap: none; addresses are a full power of two, so every address is valid.
- Reset mid-operation:
  - In-flight reads are discarded (valid bits cleared) and the init sweep restarts from address 0.
  - A write on the edge where rst_n asserts is dropped.
- Widths: all comparisons are at ADDR_WIDTH. The init counter is ADDR_WIDTH+1 bits so DEPTH is reachable without overflow.

Decomposition:
- Package kanagawa_hal_mock_ram_pkg holds:
  - state enum (INIT, RUN);
  - RDW_OLD_DATA=0 and RDW_NEW_DATA=1 constants;
  - function merge_bytes(old, new, be, BYTE_WIDTH).
- Sub-module kanagawa_hal_mock_ram_rd_pipe holds the READ_LATENCY-deep data+valid shift pipe:
  - inputs: clk, rst_n, in_valid, in_data;
  - outputs: out_valid, out_data;
  - data registers load only when valid; valid bits are reset asynchronously.

Test Plan:
- Reset, DEPTH=512, INIT_VALUE=32'hA5A5A5A5 → ready_out=0 for 511 cycles and 1 on cycle 512. Read of addr 0x1FF returns 32'hA5A5A5A5 with rdvalid_out after 2 cycles.
- Write addr 5 = 32'h11223344 with byteen=4'b1111, then byteen=4'b0101 with data 32'hFFFFFFFF → read addr 5 returns 32'h11FF33FF.
- Same-cycle write and read of addr 7 (old 0, new 32'hDEADBEEF, be=4'b1111) → RDW_MODE=0 returns 0; RDW_MODE=1 returns 32'hDEADBEEF.
- READ_LATENCY=4, reads of addrs 0..7 on 8 consecutive cycles → 8 consecutive rdvalid_out pulses in address order, the first exactly 4 cycles after the first rden_in.
- wren_in/rden_in during INIT (addr 3, 32'h12345678) → no rdvalid_out. After ready_out, addr 3 reads INIT_VALUE.
- rst_n asserted with 2 reads in flight → rdvalid_out=0 immediately, no valid output after release. ready_out drops and re-rises after DEPTH cycles.

Source files
------------

// File: rtl/kanagawa_hal_mock_ram_pkg.sv
// rtl/kanagawa_hal_mock_ram_pkg.sv - shared types and helpers for the HAL mock RAMs
package kanagawa_hal_mock_ram_pkg;

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam int RDW_OLD_DATA = 0;
   localparam int RDW_NEW_DATA = 1;

   // Widest word the merge helper handles; callers size-cast in and out.
   localparam int MAX_DATA_WIDTH = 256;
   localparam int MAX_NUM_BYTES  = 256;

   function automatic logic [MAX_DATA_WIDTH-1:0] merge_bytes(
      input logic [MAX_DATA_WIDTH-1:0] old_word,
      input logic [MAX_DATA_WIDTH-1:0] new_word,
      input logic [MAX_NUM_BYTES-1:0]  be,
      input int                        byte_width
   );
      logic [MAX_DATA_WIDTH-1:0] res;
      res = old_word;
      for (int i = 0; i < MAX_DATA_WIDTH; i++) begin
         if (be[i / byte_width]) res[i] = new_word[i];
      end
      return res;
   endfunction

endpackage

// File: rtl/kanagawa_hal_mock_ram_rd_pipe.sv
// rtl/kanagawa_hal_mock_ram_rd_pipe.sv - fixed-depth read data/valid shift pipe
module kanagawa_hal_mock_ram_rd_pipe #(
   parameter int LATENCY = 2,
   parameter int WIDTH   = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data
);

   logic [LATENCY-1:0] valid_q;
   logic [WIDTH-1:0]   data_q [LATENCY];

   // Data stages only load behind a valid bit so the output word holds between reads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         for (int i = 0; i < LATENCY; i++) data_q[i] <= '0;
      end else begin
         valid_q[0] <= in_valid;
         if (in_valid) data_q[0] <= in_data;
         for (int i = 1; i < LATENCY; i++) begin
            valid_q[i] <= valid_q[i-1];
            if (valid_q[i-1]) data_q[i] <= data_q[i-1];
         end
      end
   end

   assign out_valid = valid_q[LATENCY-1];
   assign out_data  = data_q[LATENCY-1];

endmodule

// File: rtl/kanagawa_hal_mock_sp_ram_ext.sv
// rtl/kanagawa_hal_mock_sp_ram_ext.sv - single-clock 1R1W mock RAM with init sweep
module kanagawa_hal_mock_sp_ram_ext
   import kanagawa_hal_mock_ram_pkg::*;
#(
   parameter int                    DATA_WIDTH    = 32,
   parameter int                    ADDR_WIDTH    = 9,
   parameter int                    BYTE_WIDTH    = 8,
   parameter int                    READ_LATENCY  = 2,
   parameter int                    RDW_MODE      = 0,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE    = '0,
   parameter string                 DEVICE_FAMILY = "mock"
) (
   input  logic                             clk,
   input  logic                             rst_n,
   output logic                             ready_out,
   input  logic                             rden_in,
   input  logic [ADDR_WIDTH-1:0]            readaddr_in,
   output logic                             rdvalid_out,
   output logic [DATA_WIDTH-1:0]            data_out,
   input  logic                             wren_in,
   input  logic [ADDR_WIDTH-1:0]            writeaddr_in,
   input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] byteen_in,
   input  logic [DATA_WIDTH-1:0]            data_in
);

   localparam int DEPTH     = 2 ** ADDR_WIDTH;
   localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;

   if (BYTE_WIDTH < 1 || DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_byte_width
      $error("DATA_WIDTH must be a non-zero multiple of BYTE_WIDTH");
   end
   if (DATA_WIDTH > MAX_DATA_WIDTH) begin : g_bad_data_width
      $error("DATA_WIDTH exceeds the merge helper width");
   end
   if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
      $error("READ_LATENCY must be in 1..4");
   end
   if (RDW_MODE != RDW_OLD_DATA && RDW_MODE != RDW_NEW_DATA) begin : g_bad_rdw
      $error("RDW_MODE must be 0 or 1");
   end
   if (DEVICE_FAMILY == "") begin : g_bad_family
      $error("DEVICE_FAMILY must not be empty");
   end

   state_t                state;
   logic [ADDR_WIDTH:0]   init_cnt;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  rd_fire;
   logic                  wr_fire;
   logic                  sweep_we;
   logic [DATA_WIDTH-1:0] rd_word;
   logic [DATA_WIDTH-1:0] wr_word;

   assign rd_fire   = rden_in && (state == ST_RUN);
   assign wr_fire   = wren_in && (state == ST_RUN);
   assign sweep_we  = (state == ST_INIT) && !init_cnt[ADDR_WIDTH];
   assign ready_out = (state == ST_RUN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_INIT;
         init_cnt <= '0;
      end else if (sweep_we) begin
         init_cnt <= init_cnt + 1'b1;
         if (init_cnt[ADDR_WIDTH-1:0] == {ADDR_WIDTH{1'b1}}) state <= ST_RUN;
      end
   end

   always_comb begin
      rd_word = mem[readaddr_in];
      wr_word = DATA_WIDTH'(merge_bytes(MAX_DATA_WIDTH'(mem[writeaddr_in]),
                                        MAX_DATA_WIDTH'(data_in),
                                        MAX_NUM_BYTES'(byteen_in),
                                        BYTE_WIDTH));
      // The merged word is exactly what lands in the array, so new-data mode forwards it.
      if (RDW_MODE == RDW_NEW_DATA && wr_fire && writeaddr_in == readaddr_in) rd_word = wr_word;
   end

   // Reset asserts state asynchronously, so a write on the resetting edge sees ST_INIT.
   always_ff @(posedge clk) begin
      if (wr_fire) begin
         mem[writeaddr_in] <= wr_word;
      end else if (sweep_we) begin
         mem[init_cnt[ADDR_WIDTH-1:0]] <= INIT_VALUE;
      end
   end

   kanagawa_hal_mock_ram_rd_pipe #(
      .LATENCY (READ_LATENCY),
      .WIDTH   (DATA_WIDTH)
   ) u_rd_pipe (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (rd_fire),
      .in_data   (rd_word),
      .out_valid (rdvalid_out),
      .out_data  (data_out)
   );

endmodule

// File: tb/tb_kanagawa_hal_mock_sp_ram_ext.sv
// tb/tb_kanagawa_hal_mock_sp_ram_ext.sv - self-checking bench for the single-clock mock RAM
module tb_kanagawa_hal_mock_sp_ram_ext;

   localparam int DEPTH = 512;
   localparam int LA    = 2;
   localparam int LB    = 4;
   localparam logic [31:0] INIT_A = 32'hA5A5A5A5;
   localparam logic [31:0] INIT_B = 32'h5A5A0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rden, wren;
   logic [8:0]  raddr, waddr;
   logic [3:0]  byteen;
   logic [31:0] din;
   logic        ready_a, valid_a, ready_b, valid_b;
   logic [31:0] dout_a, dout_b;

   int checks   = 0;
   int failures = 0;

   logic [31:0] mem_a [DEPTH];
   logic [31:0] mem_b [DEPTH];
   logic [31:0] pd_a [int];
   logic [31:0] pd_b [int];
   logic [31:0] last_a, last_b;
   int          n_since_rel;
   int          g;

   always #5 clk = ~clk;

   kanagawa_hal_mock_sp_ram_ext #(
      .READ_LATENCY (LA), .RDW_MODE (0), .INIT_VALUE (INIT_A)
   ) dut_a (
      .clk (clk), .rst_n (rst_n), .ready_out (ready_a),
      .rden_in (rden), .readaddr_in (raddr), .rdvalid_out (valid_a), .data_out (dout_a),
      .wren_in (wren), .writeaddr_in (waddr), .byteen_in (byteen), .data_in (din)
   );

   kanagawa_hal_mock_sp_ram_ext #(
      .READ_LATENCY (LB), .RDW_MODE (1), .INIT_VALUE (INIT_B)
   ) dut_b (
      .clk (clk), .rst_n (rst_n), .ready_out (ready_b),
      .rden_in (rden), .readaddr_in (raddr), .rdvalid_out (valid_b), .data_out (dout_b),
      .wren_in (wren), .writeaddr_in (waddr), .byteen_in (byteen), .data_in (din)
   );

   task automatic chk_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_bit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] lane_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] be);
      logic [31:0] r;
      r = old_w;
      for (int l = 0; l < 4; l++) if (be[l]) r[l*8 +: 8] = new_w[l*8 +: 8];
      return r;
   endfunction

   task automatic model_reset();
      pd_a.delete();
      pd_b.delete();
      last_a      = '0;
      last_b      = '0;
      n_since_rel = 0;
   endtask

   task automatic check_outputs();
      logic ready_exp, ev_a, ev_b;
      ready_exp = (n_since_rel >= DEPTH);
      ev_a = (pd_a.exists(g - LA + 1) != 0);
      ev_b = (pd_b.exists(g - LB + 1) != 0);
      if (!rst_n) begin
         ready_exp = 1'b0;
         ev_a      = 1'b0;
         ev_b      = 1'b0;
      end
      if (ev_a) last_a = pd_a[g - LA + 1];
      if (ev_b) last_b = pd_b[g - LB + 1];
      chk_bit ("ready_a", ready_a, ready_exp);
      chk_bit ("ready_b", ready_b, ready_exp);
      chk_bit ("rdvalid_a", valid_a, ev_a);
      chk_bit ("rdvalid_b", valid_b, ev_b);
      chk_word("data_a", dout_a, last_a);
      chk_word("data_b", dout_b, last_b);
   endtask

   // One clock: apply the RAM rules to the inputs present at the edge, then check.
   task automatic tick();
      @(posedge clk);
      g++;
      if (rst_n) begin
         if (n_since_rel >= DEPTH) begin
            if (rden) begin
               pd_a[g] = mem_a[raddr];
               pd_b[g] = (wren && waddr == raddr) ? lane_merge(mem_b[raddr], din, byteen)
                                                   : mem_b[raddr];
            end
            if (wren) begin
               mem_a[waddr] = lane_merge(mem_a[waddr], din, byteen);
               mem_b[waddr] = lane_merge(mem_b[waddr], din, byteen);
            end
         end
         n_since_rel++;
         if (n_since_rel == DEPTH) begin
            for (int i = 0; i < DEPTH; i++) begin
               mem_a[i] = INIT_A;
               mem_b[i] = INIT_B;
            end
         end
      end
      #1;
      check_outputs();
   endtask

   task automatic idle();
      rden = 1'b0; wren = 1'b0; byteen = 4'h0; din = '0; raddr = '0; waddr = '0;
   endtask

   task automatic write(input logic [8:0] a, input logic [31:0] d, input logic [3:0] be);
      wren = 1'b1; waddr = a; din = d; byteen = be;
      tick();
      wren = 1'b0;
   endtask

   // Single read (optionally with a same-cycle write) and explicit expected results per instance.
   task automatic rw(input logic [8:0] ra, input logic do_wr, input logic [31:0] wd,
                     input logic [3:0] be, input logic [31:0] exp_a, input logic [31:0] exp_b);
      rden = 1'b1; raddr = ra;
      wren = do_wr; waddr = ra; din = wd; byteen = be;
      for (int i = 1; i <= LB; i++) begin
         tick();
         rden = 1'b0; wren = 1'b0;
         if (i == LA) begin
            chk_bit ("rw_valid_a", valid_a, 1'b1);
            chk_word("rw_data_a", dout_a, exp_a);
         end
         if (i == LB) begin
            chk_bit ("rw_valid_b", valid_b, 1'b1);
            chk_word("rw_data_b", dout_b, exp_b);
         end
      end
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      g = 0;
      idle();
      model_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_outputs();
      release_reset();

      // Init sweep, with traffic that must be ignored.
      for (int i = 1; i <= DEPTH; i++) begin
         if (i >= 100 && i < 110) begin
            rden = 1'b1; raddr = 9'd3;
            wren = 1'b1; waddr = 9'd3; din = 32'h12345678; byteen = 4'hF;
         end else begin
            idle();
         end
         tick();
         if (i == DEPTH - 1) chk_bit("ready_before_512", ready_a, 1'b0);
         if (i == DEPTH)     chk_bit("ready_at_512", ready_a, 1'b1);
      end
      idle();

      rw(9'h1FF, 1'b0, '0, 4'h0, INIT_A, INIT_B);
      rw(9'd3,   1'b0, '0, 4'h0, INIT_A, INIT_B);

      write(9'd5, 32'h11223344, 4'b1111);
      write(9'd5, 32'hFFFFFFFF, 4'b0101);
      rw(9'd5, 1'b0, '0, 4'h0, 32'h11FF33FF, 32'h11FF33FF);

      write(9'd7, 32'h0, 4'b1111);
      rw(9'd7, 1'b1, 32'hDEADBEEF, 4'b1111, 32'h0, 32'hDEADBEEF);
      write(9'd9, 32'hCAFEF00D, 4'b0000);
      rw(9'd9, 1'b0, '0, 4'h0, INIT_A, INIT_B);

      // Back-to-back burst over addresses 0..7.
      for (int a = 0; a < 8; a++) begin
         rden = 1'b1; raddr = 9'(a);
         tick();
      end
      idle();
      repeat (LB) tick();

      // Reset with reads still in flight.
      rden = 1'b1; raddr = 9'd1; tick();
      raddr = 9'd2; tick();
      idle();
      rst_n = 1'b0;
      #1;
      model_reset();
      chk_bit("rst_valid_a", valid_a, 1'b0);
      chk_bit("rst_valid_b", valid_b, 1'b0);
      chk_bit("rst_ready_a", ready_a, 1'b0);
      chk_word("rst_data_b", dout_b, 32'h0);
      tick();
      release_reset();
      for (int i = 1; i <= DEPTH; i++) tick();
      chk_bit("ready_again", ready_b, 1'b1);

      // Randomised traffic over a small window to force collisions.
      for (int i = 0; i < 400; i++) begin
         rden   = 1'($urandom_range(0, 1));
         wren   = 1'($urandom_range(0, 1));
         raddr  = 9'($urandom_range(0, 15));
         waddr  = ($urandom_range(0, 3) == 0) ? raddr : 9'($urandom_range(0, 15));
         byteen = 4'($urandom);
         din    = $urandom;
         tick();
      end
      idle();
      repeat (LB + 1) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
